bram_responder: RTL and testbench
=================================

# bram_responder

Memory-side responder for the core's BRAM port: accepts the address/enable/byte-write/output-reset signals driven by the instruction or data master and returns read data with a fixed, parameterizable latency. It also has a streaming load port (valid/ready) for preloading program images into the array before the core runs. It sits in the UVM environment as the memory model behind the BRAM interface and is synthesizable as on-chip instruction/data RAM.

## Interface
- DATA_WIDTH, 32, word width; byte lanes = DATA_WIDTH/8 = 4
- ADDR_WIDTH, 15, byte address width; depth = 2^(ADDR_WIDTH-2) = 8192 words
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- bram_din  in  DATA_WIDTH  write data
- bram_dout  out  DATA_WIDTH  read data, registered
- bram_addr  in  ADDR_WIDTH  byte address; word index = bram_addr[ADDR_WIDTH-1:2], bits [1:0] ignored
- bram_en  in  1  port enable; no read, write or output reset without it
- bram_reset  in  1  synchronous output-register reset (qualified by bram_en)
- bram_we  in  4  per-byte write enables, bit i writes lane [8i+7:8i]
- load_start  in  1  start a preload burst (sampled in IDLE only)
- load_base  in  ADDR_WIDTH-2  first word index of burst
- load_len  in  ADDR_WIDTH-1  word count, 0..8192
- load_valid  in  1  load word valid
- load_data  in  DATA_WIDTH  load word
- load_ready  out  1  load word accepted when load_valid & load_ready
- load_busy  out  1  high while not IDLE
- load_done  out  1  one-cycle pulse at burst end

## Operation
- Reset (rst low): bram_dout = 0, pipeline register = 0, FSM = IDLE, load_ready/load_busy/load_done = 0, beat counter = 0. Array contents are not reset.
- Port access (FSM IDLE, bram_en=1): read-first — dout path captures the old word even when bram_we writes the same word this cycle; lanes with bram_we[i]=1 updated, others kept; bram_we=0 is a pure read.
- bram_reset=1 with bram_en=1: all output pipeline registers load 0, overriding the read; the write (if any) still happens.
- bram_en=0: no array access; bram_dout holds its value.
- Loader FSM states IDLE, LOAD, DONE:
  - IDLE: load_start & load_len!=0 -> LOAD, counter=0, address latched from load_base. load_start & load_len==0 -> DONE directly.
  - LOAD: load_ready=1; each accepted beat writes full word to (load_base+counter) mod 8192 (wraps past last word), counter++. Beat with counter==load_len-1 -> DONE.
  - DONE: load_done=1 for exactly one cycle -> IDLE.
- load_start while busy is ignored; load_base/load_len are sampled only on the accepting cycle.
- While load_busy=1 the BRAM port is fully ignored (writes dropped, bram_reset ignored, bram_dout held).
- rst asserted mid-burst: FSM -> IDLE immediately, already written words stay in the array, no load_done.

## Timing
- READ_LATENCY=1: bram_en/bram_addr sampled at edge N, bram_dout valid after edge N.
- READ_LATENCY=2: valid after edge N+1; issuing one read per cycle gives one result per cycle.
- Write visible to a read sampled at edge N+1 or later.
- Load beat accepted at edge N, visible to a port read from edge N+1 once IDLE.
- load_start at edge N -> load_busy and load_ready high from edge N+1; last beat at edge M -> load_done high in cycle M+1, load_busy low from edge M+2.

## Structure
- Package bram_responder_pkg: load_state_e enum (IDLE, LOAD, DONE), word_idx function (byte address -> word index), depth localparam derivation.
- Sub-module bram_responder_loader: FSM, beat counter, address generation and load handshake; outputs write strobe/index/data to the array.
- Top holds the array, byte-lane write merge, port/loader mux and read pipeline.

## Test plan
- Reset then read: rst low 3 cycles, read addr 0x0000 -> bram_dout=0x00000000 after reset, FSM IDLE, load_busy=0.
- Byte writes: write 0xAABBCCDD we=4'hF at 0x0010, then 0x11223344 we=4'b0101 -> read 0x0010 returns 0xAA22CC44 after READ_LATENCY.
- Read-first collision: 0x0020 holds 0x12345678; write 0xDEADBEEF we=4'hF same cycle as read -> dout=0x12345678, next read 0xDEADBEEF.
- bram_reset: dout=0xDEADBEEF, then bram_en=1 bram_reset=1 -> dout=0 next cycle; bram_en=0 bram_reset=1 -> dout unchanged.
- Load with wrap and backpressure: load_base=8190, load_len=4, data 1..4 with load_valid gapped -> words 8190,8191,0,1 hold 1,2,3,4; single load_done pulse; port write during load dropped.
- Edge cases: load_len=0 -> load_done one cycle later, no array writes; rst mid-burst after 2 of 5 beats -> first 2 words written, no load_done, load_busy=0.

Source files
------------

// File: rtl/bram_responder_pkg.sv
// Shared types and helpers for the BRAM responder and its preload engine.
package bram_responder_pkg;

    localparam int unsigned DATA_WIDTH_DFLT = 32;
    localparam int unsigned ADDR_WIDTH_DFLT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // Words addressable by a byte address of the given width.
    function automatic int unsigned depth_words(input int unsigned addr_width);
        return 32'd1 << (addr_width - 2);
    endfunction

    // Byte address to word index; the two lane-select bits are dropped.
    function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/bram_responder_loader.sv
// Preload engine: accepts a burst of words over valid/ready and emits one
// full-word write strobe per accepted beat, wrapping at the top of the array.
module bram_responder_loader
    import bram_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int unsigned IDX_WIDTH  = ADDR_WIDTH_DFLT - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [IDX_WIDTH-1:0]  load_base,
    input  logic [IDX_WIDTH:0]    load_len,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  o_wr_en_c,
    output logic [IDX_WIDTH-1:0]  o_wr_idx_c,
    output logic [DATA_WIDTH-1:0] o_wr_data_c
);

    localparam int unsigned CNT_WIDTH = IDX_WIDTH + 1;

    load_state_e            r_state;
    load_state_e            w_next;
    logic                   w_accept;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_len;
    logic [IDX_WIDTH-1:0]   r_base;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == r_len - CNT_WIDTH'(1)) begin
                        w_next = DONE;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_base     <= '0;
            load_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            r_state    <= w_next;
            load_ready <= (w_next == LOAD);
            load_busy  <= (w_next != IDLE);
            load_done  <= (w_next == DONE);
            if (r_state == IDLE && load_start) begin
                r_cnt  <= '0;
                r_len  <= load_len;
                r_base <= load_base;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_wr_en_c   = w_accept;
    assign o_wr_idx_c  = r_base + IDX_WIDTH'(r_cnt);
    assign o_wr_data_c = load_data;

endmodule

// File: rtl/bram_responder.sv
// BRAM-port memory responder: byte-writable read-first RAM with a fixed
// 1- or 2-cycle read pipeline, plus a streaming preload port.
module bram_responder
    import bram_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DFLT,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DFLT,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   bram_din,
    output logic [DATA_WIDTH-1:0]   bram_dout,
    input  logic [ADDR_WIDTH-1:0]   bram_addr,
    input  logic                    bram_en,
    input  logic                    bram_reset,
    input  logic [DATA_WIDTH/8-1:0] bram_we,
    input  logic                    load_start,
    input  logic [ADDR_WIDTH-3:0]   load_base,
    input  logic [ADDR_WIDTH-2:0]   load_len,
    input  logic                    load_valid,
    input  logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_ready,
    output logic                    load_busy,
    output logic                    load_done
);

    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = depth_words(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [IDX_WIDTH-1:0]  w_port_idx;
    logic                  w_ld_wr_en;
    logic [IDX_WIDTH-1:0]  w_ld_idx;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [LANES-1:0]      w_wr_we;
    logic [IDX_WIDTH-1:0]  w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_word;

    bram_responder_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .o_wr_en_c   (w_ld_wr_en),
        .o_wr_idx_c  (w_ld_idx),
        .o_wr_data_c (w_ld_data)
    );

    assign w_port_idx = IDX_WIDTH'(word_idx(32'(bram_addr)));
    assign w_rd_en    = bram_en & ~load_busy;
    assign w_rd_word  = r_mem[w_port_idx];

    // The loader owns the write port for the whole burst, including DONE.
    always_comb begin
        w_wr_we   = '0;
        w_wr_idx  = w_port_idx;
        w_wr_data = bram_din;
        if (load_busy) begin
            w_wr_we   = {LANES{w_ld_wr_en}};
            w_wr_idx  = w_ld_idx;
            w_wr_data = w_ld_data;
        end else if (bram_en) begin
            w_wr_we = bram_we;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (w_wr_we[i]) begin
                r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    // Read pipeline; the non-blocking array write makes reads return the old word.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_pipe;
        logic                  r_pipe_vld;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipe     <= '0;
                r_pipe_vld <= 1'b0;
                bram_dout  <= '0;
            end else begin
                r_pipe_vld <= w_rd_en;
                if (w_rd_en) begin
                    r_pipe <= bram_reset ? '0 : w_rd_word;
                end
                if (w_rd_en && bram_reset) begin
                    bram_dout <= '0;
                end else if (r_pipe_vld) begin
                    bram_dout <= r_pipe;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bram_dout <= '0;
            end else if (w_rd_en) begin
                bram_dout <= bram_reset ? '0 : w_rd_word;
            end
        end
    end

endmodule

// File: tb/tb_bram_responder.sv
// Randomized self-checking bench for bram_responder against a word-array model.
module tb_bram_responder;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic [14:0] bram_addr;
    logic        bram_en;
    logic        bram_reset;
    logic [3:0]  bram_we;
    logic        load_start;
    logic [12:0] load_base;
    logic [13:0] load_len;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_dout;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    bram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_reset (bram_reset),
        .bram_we    (bram_we),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One port cycle; the model returns the pre-write word (read-first).
    task automatic port_op(input logic en, input int idx, input logic [31:0] din,
                           input logic [3:0] we, input logic rs, input string tag);
        logic [31:0] old;
        old        = mem_m[idx];
        bram_en    = en;
        bram_addr  = 15'(idx * 4) | 15'($urandom_range(0, 3));
        bram_din   = din;
        bram_we    = we;
        bram_reset = rs;
        step();
        if (en) begin
            exp_dout = rs ? 32'h0 : old;
            for (int i = 0; i < 4; i++)
                if (we[i]) mem_m[idx][8*i +: 8] = din[8*i +: 8];
        end
        bram_en    = 1'b0;
        bram_we    = 4'h0;
        bram_reset = 1'b0;
        check_eq(tag, bram_dout, exp_dout);
    endtask

    // Burst load; seq selects data 1..len, abort_after asserts rst before that beat.
    task automatic do_load(input int base, input int len, input bit seq,
                           input int abort_after, input string tag);
        logic [31:0] d;
        load_base  = 13'(base);
        load_len   = 14'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_base  = 13'($urandom);
        load_len   = 14'($urandom);
        if (len == 0) begin
            check_eq({tag, "_done0"}, 32'(load_done), 32'd1);
            check_eq({tag, "_busy0"}, 32'(load_busy), 32'd1);
            check_eq({tag, "_rdy0"},  32'(load_ready), 32'd0);
            step();
            check_eq({tag, "_done0_end"}, 32'(load_done), 32'd0);
            check_eq({tag, "_busy0_end"}, 32'(load_busy), 32'd0);
            return;
        end
        check_eq({tag, "_busy"}, 32'(load_busy), 32'd1);
        check_eq({tag, "_rdy"},  32'(load_ready), 32'd1);
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) begin
                rst = 1'b0;
                #1;
                check_eq({tag, "_abort_busy"}, 32'(load_busy), 32'd0);
                check_eq({tag, "_abort_done"}, 32'(load_done), 32'd0);
                check_eq({tag, "_abort_dout"}, bram_dout, 32'h0);
                exp_dout = 32'h0;
                step();
                step();
                rst = 1'b1;
                step();
                check_eq({tag, "_post_abort_done"}, 32'(load_done), 32'd0);
                check_eq({tag, "_post_abort_busy"}, 32'(load_busy), 32'd0);
                return;
            end
            if (i == 1 || $urandom_range(0, 2) == 0) begin
                // Gap cycle with a port write and output reset that must be dropped.
                load_valid = 1'b0;
                bram_en    = 1'b1;
                bram_we    = 4'hF;
                bram_reset = 1'($urandom_range(0, 1));
                bram_addr  = 15'(5 * 4);
                bram_din   = 32'hBAD0BAD0;
                step();
                bram_en    = 1'b0;
                bram_we    = 4'h0;
                bram_reset = 1'b0;
                check_eq({tag, "_gap_done"}, 32'(load_done), 32'd0);
                check_eq({tag, "_gap_dout"}, bram_dout, exp_dout);
            end
            d          = seq ? 32'(i + 1) : $urandom;
            load_valid = 1'b1;
            load_data  = d;
            step();
            load_valid = 1'b0;
            mem_m[(base + i) % DEPTH] = d;
            check_eq({tag, "_beat_done"}, 32'(load_done), (i == len - 1) ? 32'd1 : 32'd0);
        end
        check_eq({tag, "_last_busy"}, 32'(load_busy), 32'd1);
        step();
        check_eq({tag, "_end_done"}, 32'(load_done), 32'd0);
        check_eq({tag, "_end_busy"}, 32'(load_busy), 32'd0);
        check_eq({tag, "_end_rdy"},  32'(load_ready), 32'd0);
    endtask

    initial begin
        int base;
        int len;
        rst        = 1'b0;
        bram_din   = '0;
        bram_addr  = '0;
        bram_en    = 1'b0;
        bram_reset = 1'b0;
        bram_we    = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_len   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        exp_dout   = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        repeat (3) step();
        check_eq("rst_dout", bram_dout, 32'h0);
        check_eq("rst_busy", 32'(load_busy), 32'd0);
        check_eq("rst_rdy",  32'(load_ready), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        rst = 1'b1;
        step();

        // Initialise the words the directed and random tests read back.
        port_op(1'b1, 0, 32'h0, 4'hF, 1'b0, "init0");
        port_op(1'b1, 3, 32'h33333333, 4'hF, 1'b0, "init3");
        port_op(1'b1, 5, 32'h55555555, 4'hF, 1'b0, "init5");

        port_op(1'b1, 4, 32'hAABBCCDD, 4'hF, 1'b0, "bw_full");
        port_op(1'b1, 4, 32'h11223344, 4'b0101, 1'b0, "bw_part");
        port_op(1'b1, 4, 32'h0, 4'h0, 1'b0, "bw_read");
        check_eq("bw_value", bram_dout, 32'hAA22CC44);

        port_op(1'b1, 8, 32'h12345678, 4'hF, 1'b0, "col_init");
        port_op(1'b1, 8, 32'hDEADBEEF, 4'hF, 1'b0, "col_rw");
        check_eq("col_old", bram_dout, 32'h12345678);
        port_op(1'b1, 8, 32'h0, 4'h0, 1'b0, "col_new");
        check_eq("col_value", bram_dout, 32'hDEADBEEF);

        port_op(1'b1, 8, 32'h0, 4'h0, 1'b1, "orst_en");
        check_eq("orst_zero", bram_dout, 32'h0);
        port_op(1'b1, 8, 32'h0, 4'h0, 1'b0, "orst_reload");
        port_op(1'b0, 8, 32'h0, 4'h0, 1'b1, "orst_noen");
        check_eq("orst_hold", bram_dout, 32'hDEADBEEF);

        for (int i = 64; i < 80; i++) port_op(1'b1, i, $urandom, 4'hF, 1'b0, "rnd_init");
        for (int n = 0; n < 150; n++)
            port_op(1'($urandom_range(0, 3) != 0), 64 + $urandom_range(0, 15), $urandom,
                    4'($urandom), 1'($urandom_range(0, 9) == 0), "rnd_port");

        do_load(8190, 4, 1'b1, -1, "wrap");
        port_op(1'b1, 8190, 32'h0, 4'h0, 1'b0, "wrap_w8190");
        check_eq("wrap_v8190", bram_dout, 32'd1);
        port_op(1'b1, 8191, 32'h0, 4'h0, 1'b0, "wrap_w8191");
        check_eq("wrap_v8191", bram_dout, 32'd2);
        port_op(1'b1, 0, 32'h0, 4'h0, 1'b0, "wrap_w0");
        check_eq("wrap_v0", bram_dout, 32'd3);
        port_op(1'b1, 1, 32'h0, 4'h0, 1'b0, "wrap_w1");
        check_eq("wrap_v1", bram_dout, 32'd4);
        port_op(1'b1, 5, 32'h0, 4'h0, 1'b0, "wrap_dropped");
        check_eq("wrap_w5_kept", bram_dout, 32'h55555555);

        do_load(3, 0, 1'b0, -1, "len0");
        port_op(1'b1, 3, 32'h0, 4'h0, 1'b0, "len0_nowrite");

        for (int t = 0; t < 3; t++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 12);
            do_load(base, len, 1'b0, -1, "rnd_load");
            for (int i = 0; i < len; i++)
                port_op(1'b1, (base + i) % DEPTH, 32'h0, 4'h0, 1'b0, "rnd_load_rd");
        end

        do_load(100, 5, 1'b1, 2, "abort");
        port_op(1'b1, 100, 32'h0, 4'h0, 1'b0, "abort_w100");
        check_eq("abort_v100", bram_dout, 32'd1);
        port_op(1'b1, 101, 32'h0, 4'h0, 1'b0, "abort_w101");
        check_eq("abort_v101", bram_dout, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
